dcnn_sn_ioif: RTL and testbench

DCNN_SN_IOIF -- requirements
Module: dcnn_sn_ioif

---
 rtl/dcnn_sn_ioif.sv | 121 ++++++++++++
 tb/tb_dcnn_sn_ioif.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dcnn_sn_ioif.sv
// Per-channel IO-to-core interface: a DEPTH-entry FIFO of wide IO entries, unpacked LSB-first
// into DW-bit words, with word decimation by a shared stride. Channels are fully independent.
module dcnn_sn_ioif #(
  parameter int unsigned DW    = 32,
  parameter int unsigned IODW  = 96,
  parameter int unsigned CH    = 2,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SW    = 3
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 clr,
  input  logic [SW-1:0]        gp_stride_size,
  input  logic [CH*IODW-1:0]   io_data_in,
  input  logic [CH-1:0]        io_data_vld,
  output logic [CH-1:0]        io_data_rdy,
  output logic [CH*DW-1:0]     core_data,
  output logic [CH-1:0]        core_vld,
  input  logic [CH-1:0]        core_rdy,
  output logic [CH-1:0]        ch_empty
);

  localparam int unsigned R   = IODW / DW;
  localparam int unsigned WSW = (R > 1) ? $clog2(R) : 1;
  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = AW + 1;

  // A stride of 0 behaves as 1.
  logic [SW-1:0] stride_eff;
  assign stride_eff = (gp_stride_size == '0) ? SW'(1) : gp_stride_size;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [IODW-1:0] mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WSW-1:0]  wsel_q, wsel_d;
    logic [SW-1:0]   ph_q, ph_d;
    logic            rdy_q, rdy_d;

    logic            empty;
    logic            push;
    logic            advance;
    logic            pop;
    logic            vld;
    logic            wsel_last;
    logic            ph_wrap;
    logic [SW:0]     ph_inc;
    logic [IODW-1:0] head;
    logic [DW-1:0]   word;

    assign empty     = (cnt_q == '0);
    assign head      = mem_q[rptr_q];
    assign word      = head[wsel_q*DW +: DW];
    assign vld       = !empty && (ph_q == '0);
    assign push      = io_data_vld[c] && rdy_q;
    // Off-phase words are dropped without waiting for the core.
    assign advance   = !empty && ((ph_q != '0) || core_rdy[c]);
    assign wsel_last = (wsel_q == WSW'(R - 1));
    assign pop       = advance && wsel_last;
    assign ph_inc    = {1'b0, ph_q} + (SW + 1)'(1);
    assign ph_wrap   = (ph_inc >= {1'b0, stride_eff});

    // Next-state for pointers, occupancy, word select, stride phase and registered ready.
    always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      wsel_d = wsel_q;
      ph_d   = ph_q;
      rdy_d  = rdy_q;
      if (clr) begin
        wptr_d = '0;
        rptr_d = '0;
        cnt_d  = '0;
        wsel_d = '0;
        ph_d   = '0;
        rdy_d  = 1'b1;
      end else begin
        if (push) wptr_d = wptr_q + AW'(1);
        if (pop)  rptr_d = rptr_q + AW'(1);
        if (advance) begin
          wsel_d = wsel_last ? '0 : wsel_q + WSW'(1);
          ph_d   = ph_wrap ? '0 : ph_inc[SW-1:0];
        end
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        rdy_d = (cnt_d < CW'(DEPTH));
      end
    end

    // Control state; async reset discards all buffered entries immediately.
    always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
        wsel_q <= '0;
        ph_q   <= '0;
        rdy_q  <= 1'b0;
      end else begin
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
        cnt_q  <= cnt_d;
        wsel_q <= wsel_d;
        ph_q   <= ph_d;
        rdy_q  <= rdy_d;
      end
    end

    // Entry storage; contents are don't-care while the count excludes them.
    always_ff @(posedge clk) begin
      if (push && !clr) mem_q[wptr_q] <= io_data_in[c*IODW +: IODW];
    end

    assign io_data_rdy[c]         = rdy_q;
    assign core_vld[c]            = vld;
    assign core_data[c*DW +: DW]  = vld ? word : '0;
    assign ch_empty[c]            = empty;
  end

endmodule

// File: tb/tb_dcnn_sn_ioif.sv
// Directed bench for dcnn_sn_ioif at DW=32, IODW=96, CH=2, DEPTH=4.
module tb_dcnn_sn_ioif;

  logic         clk = 1'b0;
  logic         arst;
  logic         clr;
  logic [2:0]   gp_stride_size;
  logic [191:0] io_data_in;
  logic [1:0]   io_data_vld;
  logic [1:0]   io_data_rdy;
  logic [63:0]  core_data;
  logic [1:0]   core_vld;
  logic [1:0]   core_rdy;
  logic [1:0]   ch_empty;

  int checks = 0;
  int errors = 0;
  logic [31:0] got[$];
  logic [31:0] exp_q[$];

  dcnn_sn_ioif #(
    .DW(32), .IODW(96), .CH(2), .DEPTH(4), .SW(3)
  ) dut (
    .clk(clk),
    .arst(arst),
    .clr(clr),
    .gp_stride_size(gp_stride_size),
    .io_data_in(io_data_in),
    .io_data_vld(io_data_vld),
    .io_data_rdy(io_data_rdy),
    .core_data(core_data),
    .core_vld(core_vld),
    .core_rdy(core_rdy),
    .ch_empty(ch_empty)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] ent(input logic [31:0] w2, input logic [31:0] w1,
                                      input logic [31:0] w0);
    return {w2, w1, w0};
  endfunction

  // Offer one entry and hold it until accepted (bounded).
  task automatic push1(input int ch, input logic [95:0] d);
    int n = 0;
    io_data_in[ch*96 +: 96] = d;
    io_data_vld[ch] = 1'b1;
    while (!io_data_rdy[ch] && n < 20) begin
      step();
      n++;
    end
    step();
    io_data_vld[ch] = 1'b0;
    check("push_timeout", 128'(n >= 20), 128'(0));
  endtask

  // Record every word presented with core_vld over ncyc cycles.
  task automatic collect(input int ch, input int ncyc);
    got.delete();
    for (int i = 0; i < ncyc; i++) begin
      if (core_vld[ch]) got.push_back(core_data[ch*32 +: 32]);
      step();
    end
  endtask

  task automatic check_seq(input string tag);
    check({tag, "_len"}, 128'(got.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check({tag, "_word"}, 128'(got[i]), 128'(exp_q[i]));
  endtask

  initial begin
    arst = 1'b1;
    clr = 1'b0;
    gp_stride_size = 3'd1;
    io_data_in = '0;
    io_data_vld = 2'b00;
    core_rdy = 2'b11;

    // Reset values, asynchronous and held across edges.
    #1;
    check("rst_rdy", 128'(io_data_rdy), 128'(2'b00));
    check("rst_vld", 128'(core_vld), 128'(2'b00));
    check("rst_data", 128'(core_data), 128'(0));
    check("rst_empty", 128'(ch_empty), 128'(2'b11));
    step();
    step();
    check("rst_rdy_held", 128'(io_data_rdy), 128'(2'b00));
    arst = 1'b0;
    step();
    check("rdy_after_rst", 128'(io_data_rdy), 128'(2'b11));

    // Stride 1: three consecutive words, no bubble.
    push1(0, ent(32'h3, 32'h2, 32'h1));
    check("s1_w1", 128'(core_data[31:0]), 128'(32'h1));
    check("s1_vld1", 128'(core_vld), 128'(2'b01));
    check("s1_ch1_data", 128'(core_data[63:32]), 128'(0));
    step();
    check("s1_w2", 128'(core_data[31:0]), 128'(32'h2));
    step();
    check("s1_w3", 128'(core_data[31:0]), 128'(32'h3));
    check("s1_vld3", 128'(core_vld[0]), 128'(1));
    step();
    check("s1_vld_end", 128'(core_vld[0]), 128'(0));
    check("s1_empty", 128'(ch_empty[0]), 128'(1));

    // Stride 2 over two entries: 1, 3, 5.
    core_rdy = 2'b00;
    gp_stride_size = 3'd2;
    push1(0, ent(32'h3, 32'h2, 32'h1));
    push1(0, ent(32'h6, 32'h5, 32'h4));
    core_rdy = 2'b11;
    collect(0, 10);
    exp_q = '{32'h1, 32'h3, 32'h5};
    check_seq("s2");
    check("s2_empty", 128'(ch_empty[0]), 128'(1));

    // Stride 4 on ch1, words 1..12: 1, 5, 9.
    core_rdy = 2'b00;
    gp_stride_size = 3'd4;
    push1(1, ent(32'd3, 32'd2, 32'd1));
    push1(1, ent(32'd6, 32'd5, 32'd4));
    push1(1, ent(32'd9, 32'd8, 32'd7));
    push1(1, ent(32'd12, 32'd11, 32'd10));
    core_rdy = 2'b11;
    collect(1, 16);
    exp_q = '{32'd1, 32'd5, 32'd9};
    check_seq("s4");
    check("s4_empty", 128'(ch_empty[1]), 128'(1));

    // Stride 0 behaves as stride 1.
    gp_stride_size = 3'd0;
    push1(0, ent(32'hC, 32'hB, 32'hA));
    collect(0, 6);
    exp_q = '{32'hA, 32'hB, 32'hC};
    check_seq("s0");

    // Backpressure on ch0 while ch1 flows.
    gp_stride_size = 3'd1;
    core_rdy = 2'b10;
    push1(0, ent(32'h13, 32'h12, 32'h11));
    push1(0, ent(32'h23, 32'h22, 32'h21));
    push1(0, ent(32'h33, 32'h32, 32'h31));
    check("bp_rdy3", 128'(io_data_rdy[0]), 128'(1));
    push1(0, ent(32'h43, 32'h42, 32'h41));
    check("bp_rdy4", 128'(io_data_rdy[0]), 128'(0));
    io_data_in[95:0] = ent(32'h53, 32'h52, 32'h51);
    io_data_vld[0] = 1'b1;
    push1(1, ent(32'hA3, 32'hA2, 32'hA1));
    check("bp_ch1_w1", 128'(core_data[63:32]), 128'(32'hA1));
    check("bp_ch0_stall", 128'(core_data[31:0]), 128'(32'h11));
    step();
    check("bp_ch1_w2", 128'(core_data[63:32]), 128'(32'hA2));
    step();
    check("bp_ch1_w3", 128'(core_data[63:32]), 128'(32'hA3));
    check("bp_rdy_held", 128'(io_data_rdy[0]), 128'(0));
    io_data_vld[0] = 1'b0;
    core_rdy = 2'b11;
    collect(0, 16);
    exp_q = '{32'h11, 32'h12, 32'h13, 32'h21, 32'h22, 32'h23,
              32'h31, 32'h32, 32'h33, 32'h41, 32'h42, 32'h43};
    check_seq("bp");
    check("bp_empty", 128'(ch_empty), 128'(2'b11));
    check("bp_rdy_end", 128'(io_data_rdy), 128'(2'b11));

    // clr mid-operation, with an entry offered on the clr edge.
    core_rdy = 2'b00;
    push1(0, ent(32'h3, 32'h2, 32'h1));
    push1(0, ent(32'h6, 32'h5, 32'h4));
    core_rdy = 2'b01;
    step();
    core_rdy = 2'b00;
    check("clr_wsel1", 128'(core_data[31:0]), 128'(32'h2));
    clr = 1'b1;
    io_data_in[95:0] = ent(32'hF3, 32'hF2, 32'hF1);
    io_data_vld[0] = 1'b1;
    step();
    clr = 1'b0;
    io_data_vld[0] = 1'b0;
    check("clr_vld", 128'(core_vld[0]), 128'(0));
    check("clr_empty", 128'(ch_empty[0]), 128'(1));
    check("clr_rdy", 128'(io_data_rdy[0]), 128'(1));
    core_rdy = 2'b01;
    push1(0, ent(32'h9, 32'h8, 32'h7));
    check("clr_w7", 128'(core_data[31:0]), 128'(32'h7));
    step();
    check("clr_w8", 128'(core_data[31:0]), 128'(32'h8));
    step();
    check("clr_w9", 128'(core_data[31:0]), 128'(32'h9));
    step();
    check("clr_end_empty", 128'(ch_empty[0]), 128'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
